// File: rtl/radio_sched_pkg.sv
// Radio transmit scheduler: state encoding, default parameters
// and a width helper shared by the scheduler and its arbiter.
package radio_sched_pkg;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_DATA_W        = 8;
    localparam int DEF_WARMUP_CYCLES = 4;
    localparam int DEF_START_TIMEOUT = 8;
    localparam int DEF_IDLE_TIMEOUT  = 16;

    typedef enum logic [2:0] {
        OFF,
        WARM,
        READY,
        SEND,
        WAIT_HI,
        WAIT_LO
    } sched_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: search starts at pointer p
// and wraps; returns a one-hot grant and its index.
module rr_arbiter
    import radio_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_w(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   p,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(p) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/radio_tx_scheduler.sv
// Shares one radio transmitter among NUM_REQ requesters, round-robin.
// Define RADIO_IDLE_PWRDN_EN to power the radio down when idle.
module radio_tx_scheduler
    import radio_sched_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int IDLE_TIMEOUT  = DEF_IDLE_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err_timeout,
    output logic                      radio_enable,
    output logic                      radio_send,
    output logic [DATA_W-1:0]         radio_tx_data,
    input  logic                      radio_busy,
    output logic                      sched_busy
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int MAX_A = (WARMUP_CYCLES > START_TIMEOUT) ?
                           WARMUP_CYCLES : START_TIMEOUT;
    // Sized for the idle timeout too, so one counter serves every state.
    localparam int CNT_MAX = (MAX_A > IDLE_TIMEOUT) ? MAX_A : IDLE_TIMEOUT;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    sched_state_t       state;
    sched_state_t       nxt;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   p;
    logic [IDX_W-1:0]   next_p;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] owner;
    logic               any_req;
    logic               take;
    logic               warm_done;
    logic               start_to;
`ifdef RADIO_IDLE_PWRDN_EN
    logic               boot;
    logic               idle_done;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req),
        .p     (p),
        .grant (grant),
        .index (grant_idx)
    );

    assign any_req   = |req;
    assign take      = (state == READY) && any_req;
    assign warm_done = (cnt == CNT_W'(WARMUP_CYCLES - 1));
    assign start_to  = (cnt == CNT_W'(START_TIMEOUT - 1));
    assign next_p    = (int'(grant_idx) == NUM_REQ - 1) ?
                       '0 : grant_idx + IDX_W'(1);
`ifdef RADIO_IDLE_PWRDN_EN
    assign idle_done = (cnt == CNT_W'(IDLE_TIMEOUT - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            OFF: begin
`ifdef RADIO_IDLE_PWRDN_EN
                if (boot || any_req) begin
                    nxt = WARM;
                end
`else
                nxt = WARM;
`endif
            end
            WARM: begin
                if (warm_done) begin
                    nxt = READY;
                end
            end
            READY: begin
                if (any_req) begin
                    nxt = SEND;
                end
`ifdef RADIO_IDLE_PWRDN_EN
                else if (idle_done) begin
                    nxt = OFF;
                end
`endif
            end
            SEND: nxt = WAIT_HI;
            WAIT_HI: begin
                if (radio_busy) begin
                    nxt = WAIT_LO;
                end else if (start_to) begin
                    nxt = READY;
                end
            end
            WAIT_LO: begin
                if (!radio_busy) begin
                    nxt = READY;
                end
            end
            default: nxt = OFF;
        endcase
    end

    always_comb begin
        radio_enable = (state != OFF);
        radio_send   = (state == SEND);
        sched_busy   = (state == SEND) || (state == WAIT_HI) ||
                       (state == WAIT_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            p             <= '0;
            owner         <= '0;
            ack           <= '0;
            err_timeout   <= 1'b0;
            radio_tx_data <= '0;
        end else begin
            ack         <= '0;
            err_timeout <= 1'b0;
            // SEND starts the busy-rise window, so the timeout is
            // measured from the send strobe itself.
            unique case (state)
                WARM:    cnt <= (nxt == WARM) ? cnt + CNT_W'(1) : '0;
                SEND:    cnt <= cnt + CNT_W'(1);
                WAIT_HI: cnt <= cnt + CNT_W'(1);
`ifdef RADIO_IDLE_PWRDN_EN
                READY:   cnt <= (nxt == READY) ? cnt + CNT_W'(1) : '0;
`endif
                default: cnt <= '0;
            endcase
            if (take) begin
                owner         <= grant;
                p             <= next_p;
                radio_tx_data <= req_data[grant_idx*DATA_W +: DATA_W];
            end
            if (state == WAIT_HI && !radio_busy && start_to) begin
                ack         <= owner;
                err_timeout <= 1'b1;
            end
            if (state == WAIT_LO && !radio_busy) begin
                ack <= owner;
            end
        end
    end

`ifdef RADIO_IDLE_PWRDN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot <= 1'b1;
        end else if (state == WARM) begin
            boot <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_radio_tx_scheduler.sv
// Scoreboard bench for radio_tx_scheduler: stimulus queues expected
// sends/acks, a monitor pops and compares them as the DUT emits them.
module tb_radio_tx_scheduler;

    localparam int NR = 4;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } send_t;

    typedef struct {
        logic [NR-1:0] vec;
        logic          err;
        int            cyc;
    } ack_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    ack;
    logic             err_timeout;
    logic             radio_enable;
    logic             radio_send;
    logic [DW-1:0]    radio_tx_data;
    logic             radio_busy = 1'b0;
    logic             sched_busy;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    busy_len = 3;
    int    r0;
    int    s0;
    send_t sq[$];
    ack_t  aq[$];
    send_t ms;
    ack_t  ma;
    logic [DW-1:0] t2d [4];

    radio_tx_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .err_timeout   (err_timeout),
        .radio_enable  (radio_enable),
        .radio_send    (radio_send),
        .radio_tx_data (radio_tx_data),
        .radio_busy    (radio_busy),
        .sched_busy    (sched_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (ack == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (ack == '0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no ack in 300 cycles, expected an ack", name);
        end
    endtask

    // Radio model: busy rises one cycle after the send and stays
    // high for busy_len cycles; busy_len of 0 means never busy.
    initial forever begin
        @(negedge clk);
        if (radio_send && busy_len > 0) begin
            @(negedge clk);
            radio_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            radio_busy = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (radio_send) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL send_unexpected: got send at cycle %0d, expected none", cyc);
            end else begin
                ms = sq.pop_front();
                chk("send_data", radio_tx_data, ms.data);
                chk("send_cycle", cyc, ms.cyc);
            end
        end
        if (ack != '0 || err_timeout) begin
            if (aq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected: got ack %b err %b at cycle %0d, expected none",
                         ack, err_timeout, cyc);
            end else begin
                ma = aq.pop_front();
                chk("ack_vec", ack, ma.vec);
                chk("ack_err", err_timeout, ma.err);
                chk("ack_cycle", cyc, ma.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1);
    end

    initial begin
        t2d[0] = 8'h10;
        t2d[1] = 8'h21;
        t2d[2] = 8'h32;
        t2d[3] = 8'h43;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_en", radio_enable, 0);
        chk("rst_send", radio_send, 0);
        chk("rst_data", radio_tx_data, 0);
        chk("rst_busy", sched_busy, 0);

        // Single request straight out of reset.
        busy_len = 3;
        req_data[7:0] = 8'hAA;
        req = 4'b0001;
        r0 = cyc;
        sq.push_back('{data: 8'hAA, cyc: r0 + 6});
        aq.push_back('{vec: 4'b0001, err: 1'b0, cyc: r0 + 11});
        rst_n = 1'b1;
        #1 chk("t1_en_off", radio_enable, 0);
        @(negedge clk);
        chk("t1_en_warm", radio_enable, 1);
        chk("t1_warm_idle", sched_busy, 0);
        wait_ack("t1");
        req = '0;
        chk("t1_data_hold", radio_tx_data, 8'hAA);

        // All four requesting continuously, pointer from reset.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        req_data = {t2d[3], t2d[2], t2d[1], t2d[0]};
        req = 4'b1111;
        busy_len = 10;
        r0 = cyc;
        for (int k = 0; k < 5; k++) begin
            sq.push_back('{data: t2d[k % 4], cyc: r0 + 6 + 13 * k});
            aq.push_back('{vec: 4'(1 << (k % 4)), err: 1'b0,
                           cyc: r0 + 18 + 13 * k});
        end
        rst_n = 1'b1;
        repeat (5) wait_ack("t2");
        req = '0;

        // Radio never goes busy: timeout ack.
        @(negedge clk);
        busy_len = 0;
        req_data[23:16] = 8'h5C;
        req = 4'b0100;
        s0 = cyc;
        sq.push_back('{data: 8'h5C, cyc: s0 + 1});
        aq.push_back('{vec: 4'b0100, err: 1'b1, cyc: s0 + 9});
        wait_ack("t3");
        req = '0;
        chk("t3_ready", sched_busy, 0);
        chk("t3_en", radio_enable, 1);

        // Request dropped right after grant still completes.
        @(negedge clk);
        busy_len = 3;
        req_data[31:24] = 8'h77;
        req = 4'b1000;
        s0 = cyc;
        sq.push_back('{data: 8'h77, cyc: s0 + 1});
        aq.push_back('{vec: 4'b1000, err: 1'b0, cyc: s0 + 6});
        @(negedge clk);
        req = '0;
        chk("t4_busy", sched_busy, 1);
        wait_ack("t4a");

        // Requester 0 keeps its request: served again after 1.
        @(negedge clk);
        req_data[7:0] = 8'hA0;
        req_data[15:8] = 8'hB1;
        req = 4'b0011;
        s0 = cyc;
        sq.push_back('{data: 8'hA0, cyc: s0 + 1});
        sq.push_back('{data: 8'hB1, cyc: s0 + 7});
        sq.push_back('{data: 8'hA0, cyc: s0 + 13});
        aq.push_back('{vec: 4'b0001, err: 1'b0, cyc: s0 + 6});
        aq.push_back('{vec: 4'b0010, err: 1'b0, cyc: s0 + 12});
        aq.push_back('{vec: 4'b0001, err: 1'b0, cyc: s0 + 18});
        repeat (3) wait_ack("t4b");
        req = '0;

        // Reset in WAIT_LO aborts without ack, then WARM repeats.
        @(negedge clk);
        busy_len = 20;
        req_data[7:0] = 8'hD4;
        req = 4'b0001;
        s0 = cyc;
        sq.push_back('{data: 8'hD4, cyc: s0 + 1});
        repeat (5) @(negedge clk);
        chk("t5_in_wait", sched_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_en", radio_enable, 0);
        chk("t5_rst_send", radio_send, 0);
        chk("t5_rst_busy", sched_busy, 0);
        chk("t5_rst_ack", ack, 0);
        chk("t5_rst_err", err_timeout, 0);
        chk("t5_rst_data", radio_tx_data, 0);
        repeat (25) @(negedge clk);
        busy_len = 3;
        r0 = cyc;
        sq.push_back('{data: 8'hD4, cyc: r0 + 6});
        aq.push_back('{vec: 4'b0001, err: 1'b0, cyc: r0 + 11});
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rewarm", radio_enable, 1);
        req_data[31:24] = 8'hEE;
        req = 4'b1001;
        repeat (2) @(negedge clk);
        req = 4'b0001;
        wait_ack("t5");
        req = '0;

`ifdef RADIO_IDLE_PWRDN_EN
        repeat (15) @(negedge clk);
        chk("idle_on", radio_enable, 1);
        @(negedge clk);
        chk("idle_off", radio_enable, 0);
        repeat (2) @(negedge clk);
        req_data[23:16] = 8'h3C;
        req = 4'b0100;
        s0 = cyc;
        sq.push_back('{data: 8'h3C, cyc: s0 + 6});
        aq.push_back('{vec: 4'b0100, err: 1'b0, cyc: s0 + 11});
        @(negedge clk);
        chk("wake_en", radio_enable, 1);
        wait_ack("wake");
        req = '0;
`else
        repeat (30) @(negedge clk);
        chk("idle_stays_on", radio_enable, 1);
        chk("idle_ready", sched_busy, 0);
`endif

        repeat (3) @(negedge clk);
        chk("sends_left", sq.size(), 0);
        chk("acks_left", aq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/radio_tx_scheduler.md
RADIO_TX_SCHEDULER -- requirements
Module: radio_tx_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing the radio transmitter.
REQ-002 The block SHALL have parameter DATA_W, default 8: byte width, matching radio tx_data.
REQ-003 The block SHALL have parameter WARMUP_CYCLES, default 4: cycles after radio enable before the first send.
REQ-004 The block SHALL have parameter START_TIMEOUT, default 8: maximum cycles from send to radio busy rising.
REQ-005 The block SHALL have parameter IDLE_TIMEOUT, default 16: idle cycles before power-down (RADIO_IDLE_PWRDN_EN only).
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low; ports are clk and rst_n.
REQ-007 clk  input  1  system clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 req  input  NUM_REQ  per-requester transmit request, level, held until ack.
REQ-010 req_data  input  NUM_REQ*DATA_W  byte per requester; slice i is bits [i*DATA_W +: DATA_W]; stable while req[i]=1.
REQ-011 ack  output  NUM_REQ  one-cycle pulse to the served requester at transfer end.
REQ-012 err_timeout  output  1  one-cycle pulse, coincident with ack, when the radio never went busy.
REQ-013 radio_enable  output  1  radio enable.
REQ-014 radio_send  output  1  one-cycle send strobe to the radio.
REQ-015 radio_tx_data  output  DATA_W  byte presented to the radio, registered.
REQ-016 radio_busy  input  1  radio busy flag.
REQ-017 sched_busy  output  1  high in SEND and WAIT_HI and WAIT_LO.

Function
REQ-018 The FSM SHALL have states OFF, WARM, READY, SEND, WAIT_HI and WAIT_LO.
REQ-019 OFF: radio_enable=0; on leaving reset, or on any req bit high (macro builds), the FSM SHALL go to WARM.
REQ-020 WARM: radio_enable=1; the FSM SHALL count WARMUP_CYCLES cycles, then go to READY; requests SHALL NOT be granted in WARM.
REQ-021 READY: if any req bit is high, the FSM SHALL select a requester round-robin, latch its byte into radio_tx_data and go to SEND in the same edge.
REQ-022 Round-robin: the search SHALL start at pointer p (0 after reset); after granting i, p SHALL become (i+1) mod NUM_REQ.
REQ-023 SEND: radio_send SHALL be 1 for exactly this one cycle; the FSM SHALL then go to WAIT_HI.
REQ-024 WAIT_HI: on radio_busy=1 the FSM SHALL go to WAIT_LO; after START_TIMEOUT cycles without it, the FSM SHALL pulse ack[i] and err_timeout and return to READY.
REQ-025 WAIT_LO: on radio_busy=0 the FSM SHALL pulse ack[i] and return to READY; there is no timeout.
REQ-026 Latency: grant edge to radio_send high SHALL be 1 cycle.
REQ-027 A req bit dropped before grant SHALL be ignored; dropped after grant, the transfer SHALL complete and ack SHALL still pulse.
REQ-028 A requester holding req after ack SHALL be re-eligible, served only after other pending requesters per REQ-022.
REQ-029 radio_tx_data SHALL hold its value from grant until the next grant.

Reset
REQ-030 On rst_n=0 the block SHALL asynchronously enter OFF with p=0, counters=0, ack=0, err_timeout=0, radio_enable=0, radio_send=0, radio_tx_data=0 and sched_busy=0.
REQ-031 Reset mid-transfer SHALL abort it without any ack; after release the FSM SHALL pass through WARM again.

Configuration
REQ-032 Macro RADIO_IDLE_PWRDN_EN defined: after IDLE_TIMEOUT consecutive READY cycles with req=0, the FSM SHALL go to OFF; from OFF any req bit SHALL trigger WARM.
REQ-033 Macro undefined: after the first WARM the FSM SHALL never re-enter OFF except by reset; the idle counter SHALL not exist.

Structure
REQ-034 The package radio_sched_pkg SHALL hold the state encoding and the default parameter constants.
REQ-035 Requester selection SHALL be in sub-module rr_arbiter (inputs req and p; outputs one-hot grant and index).

Verification
REQ-036 Release reset with req=0001 and req_data[7:0]=8'hAA -> radio_enable rises, radio_send pulses after 4 WARM cycles plus 1, radio_tx_data=8'hAA, ack=0001 one cycle after radio_busy falls.
REQ-037 Hold req=1111 continuously, model busy 10 cycles per byte -> grants are in order 0,1,2,3,0, each radio_send one cycle wide.
REQ-038 Radio model never asserts busy -> 8 cycles after radio_send, ack pulses together with err_timeout=1, and the FSM returns to READY.
REQ-039 With RADIO_IDLE_PWRDN_EN, req=0 for 16 READY cycles -> radio_enable=0; then req=0100 -> WARM for 4 cycles, then requester 2 is served.
REQ-040 Assert rst_n=0 during WAIT_LO -> all outputs are 0 immediately, no ack occurs, and WARM repeats after release.
